// File: rtl/spi_slave_frm.sv
// SPI slave with SSN-framed command + data fields, any SPI mode, double-buffered readback.
// Optional macro SPIS_MISO_TRISTATE_EN: o_miso floats whenever no frame is active.
module spi_slave_frm #(
    parameter int P_CMD_NBITS   = 8,
    parameter int P_DATA_NBITS  = 24,
    parameter int P_CPOL        = 0,
    parameter int P_CPHA        = 0,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_sclk,
    input  logic                    i_ssn,
    input  logic                    i_mosi,
    input  logic                    i_tx_load,
    input  logic [P_DATA_NBITS-1:0] i_tx_data,
    output logic                    o_miso,
    output logic [P_CMD_NBITS-1:0]  o_cmd,
    output logic                    o_cmd_vld,
    output logic [P_DATA_NBITS-1:0] o_rx_data,
    output logic                    o_rx_vld,
    output logic                    o_frame_active,
    output logic                    o_frame_err,
    output logic [1:0]              o_dbg_state
);

    localparam int F     = P_CMD_NBITS + P_DATA_NBITS;
    localparam int CNT_W = $clog2(F);
    localparam bit SAMPLE_RISE = (P_CPOL == P_CPHA);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [P_SYNC_STAGES:0] sclk_sync_q, ssn_sync_q, mosi_sync_q;
    logic [P_SYNC_STAGES:0] flush_q, flush_d;
    logic                   armed_q, armed_d;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [F-1:0]            rx_sr_q, rx_sr_d;
    logic [F-1:0]            tx_sr_q, tx_sr_d;
    logic [P_DATA_NBITS-1:0] shadow_q, shadow_d;
    logic                    miso_q, miso_d;
    logic                    first_q, first_d;
    logic [P_CMD_NBITS-1:0]  cmd_q, cmd_d;
    logic                    cmd_vld_q, cmd_vld_d;
    logic [P_DATA_NBITS-1:0] rx_data_q, rx_data_d;
    logic                    rx_vld_q, rx_vld_d;
    logic                    err_q, err_d;

    logic sclk_s, sclk_p, ssn_s, ssn_p, mosi_s;
    logic sclk_rise, sclk_fall, sample_edge, shift_edge, ssn_fall, ssn_rise;
    logic [F-1:0] rx_next;

    assign sclk_s = sclk_sync_q[P_SYNC_STAGES-1];
    assign sclk_p = sclk_sync_q[P_SYNC_STAGES];
    assign ssn_s  = ssn_sync_q[P_SYNC_STAGES-1];
    assign ssn_p  = ssn_sync_q[P_SYNC_STAGES];
    assign mosi_s = mosi_sync_q[P_SYNC_STAGES-1];

    assign sclk_rise   = sclk_s & ~sclk_p;
    assign sclk_fall   = ~sclk_s & sclk_p;
    assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    // SSN edges count only once SSN has been seen high after reset, so a frame
    // already running when reset is released is ignored.
    assign ssn_fall = armed_q & ssn_p & ~ssn_s;
    assign ssn_rise = armed_q & ~ssn_p & ssn_s;
    assign rx_next  = {rx_sr_q[F-2:0], mosi_s};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_sr_d   = rx_sr_q;
        tx_sr_d   = tx_sr_q;
        miso_d    = miso_q;
        first_d   = first_q;
        cmd_d     = cmd_q;
        rx_data_d = rx_data_q;
        cmd_vld_d = 1'b0;
        rx_vld_d  = 1'b0;
        err_d     = 1'b0;
        shadow_d  = i_tx_load ? i_tx_data : shadow_q;
        flush_d   = {flush_q[P_SYNC_STAGES-1:0], 1'b1};
        armed_d   = armed_q | (flush_q[P_SYNC_STAGES] & ssn_s);

        if (ssn_fall) begin
            state_d = ST_CMD;
            cnt_d   = CNT_W'(F - 1);
            tx_sr_d = {{P_CMD_NBITS{1'b0}}, shadow_d};
            miso_d  = (P_CPHA == 0) ? tx_sr_d[F-1] : 1'b0;
            first_d = (P_CPHA != 0);
        end else if (ssn_rise) begin
            err_d   = (state_q == ST_CMD) || (state_q == ST_DATA);
            state_d = ST_IDLE;
            miso_d  = 1'b0;
        end else if ((state_q == ST_CMD) || (state_q == ST_DATA)) begin
            if (sample_edge) begin
                rx_sr_d = rx_next;
                cnt_d   = cnt_q - 1'b1;
                if ((state_q == ST_CMD) && (cnt_q == CNT_W'(P_DATA_NBITS))) begin
                    cmd_d     = rx_next[P_CMD_NBITS-1:0];
                    cmd_vld_d = 1'b1;
                    state_d   = ST_DATA;
                end else if ((state_q == ST_DATA) && (cnt_q == '0)) begin
                    rx_data_d = rx_next[P_DATA_NBITS-1:0];
                    rx_vld_d  = 1'b1;
                    state_d   = ST_DONE;
                    miso_d    = 1'b0;
                end
            end else if (shift_edge) begin
                // CPHA=1: the first leading edge presents the MSB without shifting.
                if (first_q) begin
                    miso_d  = tx_sr_q[F-1];
                    first_d = 1'b0;
                end else begin
                    tx_sr_d = {tx_sr_q[F-2:0], 1'b0};
                    miso_d  = tx_sr_q[F-2];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sclk_sync_q <= (P_CPOL != 0) ? '1 : '0;
            ssn_sync_q  <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            shadow_q    <= '0;
            miso_q      <= 1'b0;
            first_q     <= 1'b0;
            cmd_q       <= '0;
            cmd_vld_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_vld_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[P_SYNC_STAGES-1:0], i_sclk};
            ssn_sync_q  <= {ssn_sync_q[P_SYNC_STAGES-1:0], i_ssn};
            mosi_sync_q <= {mosi_sync_q[P_SYNC_STAGES-1:0], i_mosi};
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            shadow_q    <= shadow_d;
            miso_q      <= miso_d;
            first_q     <= first_d;
            cmd_q       <= cmd_d;
            cmd_vld_q   <= cmd_vld_d;
            rx_data_q   <= rx_data_d;
            rx_vld_q    <= rx_vld_d;
            err_q       <= err_d;
        end
    end

    assign o_frame_active = armed_q & ~ssn_s;
    assign o_cmd          = cmd_q;
    assign o_cmd_vld      = cmd_vld_q;
    assign o_rx_data      = rx_data_q;
    assign o_rx_vld       = rx_vld_q;
    assign o_frame_err    = err_q;
    assign o_dbg_state    = state_q;

`ifdef SPIS_MISO_TRISTATE_EN
    assign o_miso = o_frame_active ? miso_q : 1'bz;
`else
    assign o_miso = o_frame_active & miso_q;
`endif

endmodule

// File: doc/spi_slave_frm.md
# spi_slave_frm

Parametrised SPI slave for the crossover control port: receives a command field followed by a data field in one SSN-framed transfer, in any of the four SPI modes, and returns a readback word on MISO in the same frame. It sits between the external MCU SPI pins and the register/coefficient write logic and supplies separate command and data strobes with a 1-cycle handshake. Frame-length errors are detected and reported, and TX data is double-buffered so software loads never corrupt a frame in flight.

## Interface
- P_CMD_NBITS, 8, command field width (1..16)
- P_DATA_NBITS, 24, data field width (1..32); frame length F = P_CMD_NBITS + P_DATA_NBITS
- P_CPOL, 0, SCLK idle level
- P_CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- P_SYNC_STAGES, 2, synchroniser depth for SCLK/SSN/MOSI (2..3)

- i_clk  in  1  system clock, ≥ 8× SCLK
- i_rstn  in  1  asynchronous active-low reset
- i_sclk  in  1  SPI clock from master
- i_ssn  in  1  active-low slave select
- i_mosi  in  1  master out, slave in, MSB first
- i_tx_load  in  1  load strobe for TX shadow register
- i_tx_data  in  P_DATA_NBITS  readback word
- o_miso  out  1  slave out
- o_cmd  out  P_CMD_NBITS  received command, held until next command
- o_cmd_vld  out  1  1-cycle pulse, o_cmd valid
- o_rx_data  out  P_DATA_NBITS  received data, held until next frame completes
- o_rx_vld  out  1  1-cycle pulse, full frame received
- o_frame_active  out  1  synchronised SSN low
- o_frame_err  out  1  1-cycle pulse, frame aborted short

## Operation
- Synchronise SCLK, SSN, MOSI through P_SYNC_STAGES flops, plus one extra flop for edge detect. Sample edge = rising when P_CPOL==P_CPHA, else falling; shift edge is the opposite edge.
- TX path: i_tx_load writes the shadow register at any time. On SSN falling edge, shadow is copied to the TX shift register (upper P_CMD_NBITS bits = 0, data in low bits, giving an F-bit word).
- State machine: IDLE → CMD on SSN falling edge; bit counter = F-1. CMD → DATA after sample of bit index P_DATA_NBITS (last command bit): latch o_cmd, pulse o_cmd_vld. DATA → DONE after sample of bit 0: latch o_rx_data, pulse o_rx_vld. DONE → IDLE on SSN rising edge. CMD/DATA → IDLE on SSN rising edge with o_frame_err pulse; o_rx_data and o_rx_vld are untouched (o_cmd may already be updated).
- Sampling: on each sample edge in CMD/DATA, MOSI shifts into the RX shift register and the bit counter decrements. Extra SCLK edges in DONE are ignored; MISO drives 0.
- MISO: CPHA=0: MSB is driven at frame start, and each shift edge advances one bit. CPHA=1: the first leading edge drives the MSB, and subsequent shift edges advance.
- i_tx_load and SSN falling in the same cycle: the new i_tx_data goes to both shadow and shift register.
- SSN falling while not IDLE (missed rising edge) restarts the frame in CMD.

## Timing
- Pin edge to internal detect: P_SYNC_STAGES+1 i_clk cycles.
- o_cmd_vld / o_rx_vld assert in the cycle after the detected sample edge of the final bit of the field.
- MISO updates in the cycle after the detected shift edge. Master setup margin is ½ SCLK minus (P_SYNC_STAGES+2) i_clk.
- o_frame_err asserts in the cycle after the detected SSN rising edge.
- Reset values: all outputs 0, state IDLE, shift registers and shadow 0; o_miso per Configuration. Reset asserted mid-frame aborts with no strobes. After release, a frame already in progress is ignored until the next SSN falling edge.

## Configuration
- SPIS_MISO_TRISTATE_EN defined: o_miso = 1'bz whenever o_frame_active = 0, including reset.
- SPIS_MISO_TRISTATE_EN undefined: o_miso = 0 outside a frame. This mode is for a dedicated, unshared MISO line.

## Test plan
- Mode 0 with defaults: frame cmd 0xA5, data 0x123456 -> o_cmd_vld once with o_cmd=0xA5, then o_rx_vld once with o_rx_data=0x123456, o_frame_err=0.
- Modes 1, 2 and 3, each with i_tx_load 0xC0FFEE before SSN -> master reads 0x00C0FFEE over 32 bits, and RX captures match the sent frame.
- i_tx_load 0x111111 mid-frame after preload 0xABCDEF -> current frame returns 0xABCDEF, next frame returns 0x111111.
- SSN rises after 12 bits -> o_cmd_vld=1 (cmd latched), o_frame_err pulses, o_rx_vld stays 0, o_rx_data keeps its previous value.
- 40 SCLK cycles in one frame -> exactly one o_rx_vld, and bits 33..40 are ignored.
- i_rstn pulsed low at bit 20 -> all outputs at reset values, no strobes, next complete frame decodes correctly; check o_miso = Z (macro defined) or 0 (macro undefined) while idle.
